// File: rtl/motion_pkg.sv
// -----------------------------------------------------------------------------
// motion_pkg
// Shared definitions for the motion command arbiter:
//   - motor command codes (CMD_STOP..CMD_RIGHT) and their width
//   - command source codes (SRC_NONE..SRC_TRACK)
//   - arbiter FSM state enum and the packed target payload
//   - helpers: illegal-command squashing and counter width sizing
// -----------------------------------------------------------------------------
package motion_pkg;

    localparam int unsigned CMD_W = 3;
    localparam int unsigned SRC_W = 2;

    localparam logic [CMD_W-1:0] CMD_STOP  = 3'd0;
    localparam logic [CMD_W-1:0] CMD_FWD   = 3'd1;
    localparam logic [CMD_W-1:0] CMD_BACK  = 3'd2;
    localparam logic [CMD_W-1:0] CMD_LEFT  = 3'd3;
    localparam logic [CMD_W-1:0] CMD_RIGHT = 3'd4;

    localparam logic [SRC_W-1:0] SRC_NONE  = 2'd0;
    localparam logic [SRC_W-1:0] SRC_AVOID = 2'd1;
    localparam logic [SRC_W-1:0] SRC_IR    = 2'd2;
    localparam logic [SRC_W-1:0] SRC_TRACK = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DWELL = 2'd2
    } state_e;

    // Winning command of the priority selection and who asked for it.
    typedef struct packed {
        logic [CMD_W-1:0] cmd;
        logic [SRC_W-1:0] src;
    } target_t;

    // Codes above CMD_RIGHT are undefined for the motor driver; treat as stop.
    function automatic logic [CMD_W-1:0] legal_cmd(input logic [CMD_W-1:0] c);
        return (c > CMD_RIGHT) ? CMD_STOP : c;
    endfunction

    // Counter width able to hold n; never zero so a 0 parameter still elaborates.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n == 0) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/ir_hold_timer.sv
// -----------------------------------------------------------------------------
// ir_hold_timer
// Latches the last IR command and keeps it active for HOLD_CYCLES cycles
// after the most recent strobe. A strobe always reloads, including the cycle
// the counter would otherwise expire, so repeated strobes never drop the hold.
// Ports:
//   clk, rst     system clock, synchronous active-high reset
//   clear_i      abandon hold (emergency stop)
//   load_i       IR strobe; latch cmd_i and reload the counter
//   cmd_i        decoded IR command
//   active_o     registered: hold counter is nonzero
//   cmd_o        registered: latched (squashed) IR command
// -----------------------------------------------------------------------------
module ir_hold_timer
    import motion_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 50_000_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear_i,
    input  logic             load_i,
    input  logic [CMD_W-1:0] cmd_i,
    output logic             active_o,
    output logic [CMD_W-1:0] cmd_o
);

    localparam int unsigned HW = cnt_width(HOLD_CYCLES);

    logic [HW-1:0]    cnt_q, cnt_d;
    logic [CMD_W-1:0] cmd_q, cmd_d;
    logic             active_q, active_d;

    // Next-state: clear beats reload, reload beats countdown; saturates at 0.
    always_comb begin
        cnt_d = cnt_q;
        cmd_d = cmd_q;
        if (clear_i) begin
            cnt_d = '0;
            cmd_d = CMD_STOP;
        end else if (load_i) begin
            cnt_d = HW'(HOLD_CYCLES);
            cmd_d = legal_cmd(cmd_i);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - HW'(1);
        end
        active_d = (cnt_d != '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            cmd_q    <= CMD_STOP;
            active_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            cmd_q    <= cmd_d;
            active_q <= active_d;
        end
    end

    assign active_o = active_q;
    assign cmd_o    = cmd_q;

endmodule

// File: rtl/motion_cmd_arbiter.sv
// -----------------------------------------------------------------------------
// motion_cmd_arbiter
// Selects one motor command per cycle from estop / obstacle avoidance / IR
// remote (with hold timer) / line tracking, and inserts a forced-stop dwell
// when switching between two different running commands.
// Ports:
//   clk, rst               system clock, synchronous active-high reset
//   estop                  emergency stop (level)
//   avoid_req, avoid_cmd   obstacle-avoidance request and command
//   ir_valid, ir_cmd       IR strobe and decoded command
//   track_en, track_cmd    line-tracking enable and command
//   motor_cmd              registered command to the motor driver
//   src                    registered source of motor_cmd (0 while stopped)
//   dwell                  registered, high during a forced-stop dwell
// -----------------------------------------------------------------------------
module motion_cmd_arbiter
    import motion_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 50_000_000,
    parameter int unsigned DEAD_CYCLES = 5_000_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             estop,
    input  logic             avoid_req,
    input  logic [CMD_W-1:0] avoid_cmd,
    input  logic             ir_valid,
    input  logic [CMD_W-1:0] ir_cmd,
    input  logic             track_en,
    input  logic [CMD_W-1:0] track_cmd,
    output logic [CMD_W-1:0] motor_cmd,
    output logic [SRC_W-1:0] src,
    output logic             dwell
);

    localparam int unsigned DW = cnt_width(DEAD_CYCLES);

    logic             ir_active;
    logic [CMD_W-1:0] ir_held_cmd;
    target_t          target;
    state_e           state_q;
    logic [DW-1:0]    dcnt_q;

    ir_hold_timer #(
        .HOLD_CYCLES (HOLD_CYCLES)
    ) u_ir_hold (
        .clk      (clk),
        .rst      (rst),
        .clear_i  (estop),
        .load_i   (ir_valid),
        .cmd_i    (ir_cmd),
        .active_o (ir_active),
        .cmd_o    (ir_held_cmd)
    );

    // Priority selection of this cycle's target command.
    always_comb begin
        target = '{cmd: CMD_STOP, src: SRC_NONE};
        if (estop) begin
            target = '{cmd: CMD_STOP, src: SRC_NONE};
        end else if (avoid_req) begin
            target = '{cmd: legal_cmd(avoid_cmd), src: SRC_AVOID};
        end else if (ir_active) begin
            target = '{cmd: ir_held_cmd, src: SRC_IR};
        end else if (track_en) begin
            target = '{cmd: legal_cmd(track_cmd), src: SRC_TRACK};
        end
    end

    // Arbiter FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (rst || estop) begin
            state_q   <= ST_IDLE;
            motor_cmd <= CMD_STOP;
            src       <= SRC_NONE;
            dwell     <= 1'b0;
            dcnt_q    <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (target.cmd != CMD_STOP) begin
                        state_q   <= ST_RUN;
                        motor_cmd <= target.cmd;
                        src       <= target.src;
                    end
                end
                ST_RUN: begin
                    if (target.cmd == CMD_STOP) begin
                        state_q   <= ST_IDLE;
                        motor_cmd <= CMD_STOP;
                        src       <= SRC_NONE;
                    end else if (target.cmd == motor_cmd) begin
                        // Same motion, different requester: relabel only.
                        src <= target.src;
                    end else if (DEAD_CYCLES == 0) begin
                        motor_cmd <= target.cmd;
                        src       <= target.src;
                    end else begin
                        state_q   <= ST_DWELL;
                        motor_cmd <= CMD_STOP;
                        src       <= SRC_NONE;
                        dwell     <= 1'b1;
                        dcnt_q    <= DW'(DEAD_CYCLES);
                    end
                end
                ST_DWELL: begin
                    if (target.cmd == CMD_STOP) begin
                        state_q <= ST_IDLE;
                        dwell   <= 1'b0;
                        dcnt_q  <= '0;
                    end else if (dcnt_q <= DW'(1)) begin
                        // Last dwell cycle: resume with whatever wins now.
                        state_q   <= ST_RUN;
                        motor_cmd <= target.cmd;
                        src       <= target.src;
                        dwell     <= 1'b0;
                        dcnt_q    <= '0;
                    end else begin
                        dcnt_q <= dcnt_q - DW'(1);
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    motor_cmd <= CMD_STOP;
                    src       <= SRC_NONE;
                    dwell     <= 1'b0;
                    dcnt_q    <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_motion_cmd_arbiter.sv
// -----------------------------------------------------------------------------
// tb_motion_cmd_arbiter
// Two instances share all inputs: dut_a with DEAD_CYCLES=4 and dut_b with
// DEAD_CYCLES=0. A cycle-level behavioural model (hold time left, dwell time
// left, current motion) predicts both; directed scenarios also check
// hand-derived constants.
// -----------------------------------------------------------------------------
module tb_motion_cmd_arbiter;

    localparam int unsigned HOLD = 10;
    localparam int unsigned DEAD = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       estop = 1'b0;
    logic       avoid_req = 1'b0;
    logic [2:0] avoid_cmd = 3'd0;
    logic       ir_valid = 1'b0;
    logic [2:0] ir_cmd = 3'd0;
    logic       track_en = 1'b0;
    logic [2:0] track_cmd = 3'd0;

    logic [2:0] motor_a, motor_b;
    logic [1:0] src_a, src_b;
    logic       dwell_a, dwell_b;

    int checks = 0;
    int errors = 0;

    // Behavioural model state; index 0 -> dut_a, 1 -> dut_b.
    int hold_left = 0;
    int ir_lat = 0;
    int m_motor[2] = '{0, 0};
    int m_src[2] = '{0, 0};
    int m_dwell_left[2] = '{0, 0};
    int dead_cfg[2] = '{DEAD, 0};

    always #5 clk = ~clk;

    motion_cmd_arbiter #(.HOLD_CYCLES(HOLD), .DEAD_CYCLES(DEAD)) dut_a (
        .clk(clk), .rst(rst), .estop(estop),
        .avoid_req(avoid_req), .avoid_cmd(avoid_cmd),
        .ir_valid(ir_valid), .ir_cmd(ir_cmd),
        .track_en(track_en), .track_cmd(track_cmd),
        .motor_cmd(motor_a), .src(src_a), .dwell(dwell_a)
    );

    motion_cmd_arbiter #(.HOLD_CYCLES(HOLD), .DEAD_CYCLES(0)) dut_b (
        .clk(clk), .rst(rst), .estop(estop),
        .avoid_req(avoid_req), .avoid_cmd(avoid_cmd),
        .ir_valid(ir_valid), .ir_cmd(ir_cmd),
        .track_en(track_en), .track_cmd(track_cmd),
        .motor_cmd(motor_b), .src(src_b), .dwell(dwell_b)
    );

    function automatic int san(input logic [2:0] c);
        return (c > 3'd4) ? 0 : int'(c);
    endfunction

    // One clock edge of the intended behaviour, evaluated from the inputs
    // present at that edge.
    function automatic void model_step();
        int tcmd;
        int tsrc;
        if (rst) begin
            hold_left = 0;
            ir_lat = 0;
            for (int k = 0; k < 2; k++) begin
                m_motor[k] = 0; m_src[k] = 0; m_dwell_left[k] = 0;
            end
            return;
        end
        tcmd = 0; tsrc = 0;
        if (estop) begin
            tcmd = 0;
        end else if (avoid_req) begin
            tcmd = san(avoid_cmd); tsrc = 1;
        end else if (hold_left > 0) begin
            tcmd = ir_lat; tsrc = 2;
        end else if (track_en) begin
            tcmd = san(track_cmd); tsrc = 3;
        end
        for (int k = 0; k < 2; k++) begin
            if (estop) begin
                m_motor[k] = 0; m_src[k] = 0; m_dwell_left[k] = 0;
            end else if (m_dwell_left[k] > 0) begin
                if (tcmd == 0) begin
                    m_dwell_left[k] = 0;
                end else if (m_dwell_left[k] == 1) begin
                    m_dwell_left[k] = 0; m_motor[k] = tcmd; m_src[k] = tsrc;
                end else begin
                    m_dwell_left[k] = m_dwell_left[k] - 1;
                end
            end else if (m_motor[k] == 0) begin
                m_motor[k] = tcmd;
                m_src[k] = (tcmd != 0) ? tsrc : 0;
            end else if (tcmd == 0) begin
                m_motor[k] = 0; m_src[k] = 0;
            end else if (tcmd == m_motor[k]) begin
                m_src[k] = tsrc;
            end else if (dead_cfg[k] == 0) begin
                m_motor[k] = tcmd; m_src[k] = tsrc;
            end else begin
                m_motor[k] = 0; m_src[k] = 0; m_dwell_left[k] = dead_cfg[k];
            end
        end
        if (estop) begin
            hold_left = 0; ir_lat = 0;
        end else if (ir_valid) begin
            hold_left = HOLD; ir_lat = san(ir_cmd);
        end else if (hold_left > 0) begin
            hold_left = hold_left - 1;
        end
    endfunction

    // Advance one clock; outputs are then stable 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic clear_inputs();
        estop = 0; avoid_req = 0; avoid_cmd = 0; ir_valid = 0; ir_cmd = 0;
        track_en = 0; track_cmd = 0;
    endtask

    task automatic settle();
        clear_inputs();
        repeat (HOLD + DEAD + 3) tick();
    endtask

    // Bring dut_a into the dwell between forward and backward via IR.
    task automatic enter_dwell();
        ir_cmd = 3'd1; ir_valid = 1; tick();
        ir_valid = 0; tick();
        ir_cmd = 3'd2; ir_valid = 1; tick();
        ir_valid = 0; tick();
    endtask

    task automatic test_reset();
        rst = 1; clear_inputs();
        ir_valid = 1; ir_cmd = 3'd1; track_en = 1; track_cmd = 3'd3;
        tick(); tick();
        checks++;
        if (motor_a !== 3'd0 || src_a !== 2'd0 || dwell_a !== 1'b0) begin
            errors++;
            $display("FAIL reset_a: motor=%0d src=%0d dwell=%0d required 0/0/0", motor_a, src_a, dwell_a);
        end
        checks++;
        if (motor_b !== 3'd0 || src_b !== 2'd0 || dwell_b !== 1'b0) begin
            errors++;
            $display("FAIL reset_b: motor=%0d src=%0d dwell=%0d required 0/0/0", motor_b, src_b, dwell_b);
        end
        clear_inputs();
        rst = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (motor_a !== 3'd0 || src_a !== 2'd0) begin
                errors++;
                $display("FAIL reset_residual cyc%0d: motor=%0d src=%0d required 0/0", i, motor_a, src_a);
            end
        end
    endtask

    task automatic test_ir_hold();
        int ones;
        ones = 0;
        ir_cmd = 3'd1; ir_valid = 1; tick();
        ir_valid = 0;
        for (int i = 0; i < 14; i++) begin
            tick();
            if (motor_a == 3'd1) ones++;
            checks++;
            if (motor_a !== ((i < 10) ? 3'd1 : 3'd0) || src_a !== ((i < 10) ? 2'd2 : 2'd0)) begin
                errors++;
                $display("FAIL ir_hold cyc%0d: motor=%0d src=%0d required %0d/%0d",
                         i, motor_a, src_a, (i < 10) ? 1 : 0, (i < 10) ? 2 : 0);
            end
        end
        checks++;
        if (ones != 10) begin
            errors++;
            $display("FAIL ir_hold_len: active cycles=%0d required 10", ones);
        end
        settle();
    endtask

    task automatic test_ir_change_dwell();
        ir_cmd = 3'd1; ir_valid = 1; tick();
        ir_valid = 0; tick();
        ir_cmd = 3'd2; ir_valid = 1; tick();
        ir_valid = 0;
        for (int i = 0; i < 7; i++) begin
            tick();
            checks++;
            if (motor_a !== ((i < 4) ? 3'd0 : 3'd2) || dwell_a !== (i < 4)) begin
                errors++;
                $display("FAIL ir_dwell cyc%0d: motor=%0d dwell=%0d required %0d/%0d",
                         i, motor_a, dwell_a, (i < 4) ? 0 : 2, (i < 4) ? 1 : 0);
            end
            checks++;
            if (motor_b !== 3'd2 || dwell_b !== 1'b0 || src_b !== 2'd2) begin
                errors++;
                $display("FAIL nodead_switch cyc%0d: motor=%0d dwell=%0d src=%0d required 2/0/2",
                         i, motor_b, dwell_b, src_b);
            end
        end
        settle();
    endtask

    task automatic test_src_change();
        track_en = 1; track_cmd = 3'd3; tick(); tick();
        checks++;
        if (motor_a !== 3'd3 || src_a !== 2'd3) begin
            errors++;
            $display("FAIL track_run: motor=%0d src=%0d required 3/3", motor_a, src_a);
        end
        avoid_req = 1; avoid_cmd = 3'd3;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (motor_a !== 3'd3 || src_a !== 2'd1 || dwell_a !== 1'b0) begin
                errors++;
                $display("FAIL src_change cyc%0d: motor=%0d src=%0d dwell=%0d required 3/1/0",
                         i, motor_a, src_a, dwell_a);
            end
        end
        settle();
    endtask

    task automatic test_estop_mid_dwell();
        enter_dwell();
        tick();
        checks++;
        if (dwell_a !== 1'b1) begin
            errors++;
            $display("FAIL estop_setup: dwell=%0d required 1", dwell_a);
        end
        estop = 1; tick();
        checks++;
        if (motor_a !== 3'd0 || dwell_a !== 1'b0 || src_a !== 2'd0) begin
            errors++;
            $display("FAIL estop_dwell: motor=%0d dwell=%0d src=%0d required 0/0/0", motor_a, dwell_a, src_a);
        end
        estop = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            checks++;
            if (motor_a !== 3'd0 || dwell_a !== 1'b0 || motor_b !== 3'd0) begin
                errors++;
                $display("FAIL estop_resume cyc%0d: motor_a=%0d dwell_a=%0d motor_b=%0d required 0/0/0",
                         i, motor_a, dwell_a, motor_b);
            end
        end
        settle();
    endtask

    task automatic test_ir_repeat();
        ir_cmd = 3'd4;
        for (int i = 0; i < 45; i++) begin
            ir_valid = (i % 10 == 0);
            tick();
            if (i >= 1) begin
                checks++;
                if (motor_a !== 3'd4 || src_a !== 2'd2) begin
                    errors++;
                    $display("FAIL ir_repeat cyc%0d: motor=%0d src=%0d required 4/2", i, motor_a, src_a);
                end
            end
        end
        settle();
    endtask

    task automatic test_bad_cmd();
        ir_cmd = 3'd6; ir_valid = 1; tick();
        ir_valid = 0;
        for (int i = 0; i < 5; i++) begin
            avoid_req = (i >= 3); avoid_cmd = 3'd7;
            tick();
            checks++;
            if (motor_a !== 3'd0 || src_a !== 2'd0 || dwell_a !== 1'b0) begin
                errors++;
                $display("FAIL bad_cmd cyc%0d: motor=%0d src=%0d dwell=%0d required 0/0/0",
                         i, motor_a, src_a, dwell_a);
            end
        end
        settle();
    endtask

    task automatic test_reset_mid_dwell();
        enter_dwell();
        rst = 1; tick(); tick();
        rst = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            checks++;
            if (motor_a !== 3'd0 || dwell_a !== 1'b0 || motor_b !== 3'd0) begin
                errors++;
                $display("FAIL reset_dwell cyc%0d: motor_a=%0d dwell_a=%0d motor_b=%0d required 0/0/0",
                         i, motor_a, dwell_a, motor_b);
            end
        end
        settle();
    endtask

    task automatic test_random();
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 399) == 0);
            estop = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 24) == 0) avoid_req = ~avoid_req;
            if ($urandom_range(0, 7) == 0) avoid_cmd = 3'($urandom_range(0, 7));
            ir_valid = ($urandom_range(0, 14) == 0);
            ir_cmd = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 19) == 0) track_en = ~track_en;
            if ($urandom_range(0, 9) == 0) track_cmd = 3'($urandom_range(0, 7));
            tick();
            checks++;
            if (motor_a !== 3'(m_motor[0]) || src_a !== 2'(m_src[0]) || dwell_a !== (m_dwell_left[0] > 0)) begin
                errors++;
                $display("FAIL random_a cyc%0d: motor=%0d src=%0d dwell=%0d required %0d/%0d/%0d",
                         n, motor_a, src_a, dwell_a, m_motor[0], m_src[0], m_dwell_left[0] > 0);
            end
            checks++;
            if (motor_b !== 3'(m_motor[1]) || src_b !== 2'(m_src[1]) || dwell_b !== (m_dwell_left[1] > 0)) begin
                errors++;
                $display("FAIL random_b cyc%0d: motor=%0d src=%0d dwell=%0d required %0d/%0d/%0d",
                         n, motor_b, src_b, dwell_b, m_motor[1], m_src[1], m_dwell_left[1] > 0);
            end
        end
        rst = 0;
        settle();
    endtask

    initial begin
        test_reset();
        test_ir_hold();
        test_ir_change_dwell();
        test_src_change();
        test_estop_mid_dwell();
        test_ir_repeat();
        test_bad_cmd();
        test_reset_mid_dwell();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
